// File: rtl/c880_bist_harness.sv
// Built-in self-test harness for ISCAS c880: LFSR stimulus on pi_vec, MISR
// compaction of po_vec, and an end-of-run compare against a golden signature.
module c880_bist_harness #(
   parameter int unsigned NUM_PATTERNS = 1024,
   parameter logic [59:0] SEED         = 60'h1,
   parameter logic [25:0] GOLDEN_SIG   = 26'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [59:0] pi_vec,
   input  logic [25:0] po_vec,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [25:0] signature,
   output logic [15:0] pat_cnt
);

   localparam logic [25:0] POLY     = 26'h0000047;
   // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
   localparam logic [59:0] SEED_EFF = (SEED == 60'h0) ? 60'h1 : SEED;
   localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

   state_t      state;
   logic [59:0] lfsr_next;
   logic [25:0] misr_next;

   always_comb begin
      lfsr_next = {pi_vec[58:0], pi_vec[59] ^ pi_vec[58]};
      misr_next = {signature[24:0], 1'b0} ^ (signature[25] ? POLY : '0) ^ po_vec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pi_vec    <= '0;
         signature <= '0;
         pat_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else if (abort) begin
         state  <= IDLE;
         pi_vec <= '0;
         pass   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  pi_vec    <= SEED_EFF;
                  signature <= '0;
                  pat_cnt   <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            RUN: begin
               signature <= misr_next;
               pat_cnt   <= pat_cnt + 16'd1;
               // The last pattern stays on pi_vec while its response is absorbed.
               if (pat_cnt == LAST_CNT) begin
                  state <= CHECK;
               end else begin
                  pi_vec <= lfsr_next;
               end
            end
            CHECK: begin
               state  <= DONE;
               pass   <= (signature == GOLDEN_SIG);
               pi_vec <= '0;
               busy   <= 1'b0;
               done   <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c880_bist_harness.sv
// Directed bench for c880_bist_harness: short runs with hand-derived values,
// plus longer runs against a small stimulus/compaction model and a c880 stand-in.
module tb_c880_bist_harness;

   localparam int unsigned D_N = 100;
   localparam int unsigned E_N = 64;

   logic clk, rst;

   logic start_a, abort_a, busy_a, done_a, pass_a;
   logic [25:0] po_a, sig_a;
   logic [59:0] pi_a;
   logic [15:0] cnt_a;

   logic start_b, abort_b, busy_b, done_b, pass_b;
   logic [25:0] po_b, sig_b;
   logic [59:0] pi_b;
   logic [15:0] cnt_b;

   logic start_c, abort_c, busy_c, done_c, pass_c;
   logic [25:0] po_c, sig_c;
   logic [59:0] pi_c;
   logic [15:0] cnt_c;

   logic start_d, abort_d, busy_d, done_d, pass_d;
   logic [25:0] po_d, sig_d;
   logic [59:0] pi_d;
   logic [15:0] cnt_d;

   logic start_e, abort_e, busy_e, done_e, pass_e;
   logic [25:0] po_e, sig_e;
   logic [59:0] pi_e;
   logic [15:0] cnt_e;

   logic        man_d, tamper;
   logic [25:0] po_man;

   int unsigned n_vec, n_bad;

   // Stand-in for the combinational c880; tamper pins one output at constant 1.
   function automatic logic [25:0] stub(input logic [59:0] p, input logic t);
      logic [25:0] r;
      r = p[25:0] ^ p[51:26] ^ {18'h0, p[59:52]};
      if (t) r[5] = 1'b1;
      return r;
   endfunction

   function automatic logic [25:0] model_sig(input int unsigned n, input logic [59:0] seed,
                                             input logic t);
      logic [59:0] l;
      logic [25:0] s;
      l = (seed == 60'h0) ? 60'h1 : seed;
      s = 26'h0;
      for (int unsigned k = 0; k < n; k++) begin
         s = {s[24:0], 1'b0} ^ (s[25] ? 26'h0000047 : 26'h0) ^ stub(l, t);
         l = {l[58:0], l[59] ^ l[58]};
      end
      return s;
   endfunction

   localparam logic [25:0] E_GOLD = model_sig(E_N, 60'h1, 1'b0);

   assign po_d = man_d ? po_man : stub(pi_d, 1'b0);
   assign po_e = stub(pi_e, tamper);

   c880_bist_harness #(.NUM_PATTERNS(4), .SEED(60'h1), .GOLDEN_SIG(26'h0)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .pi_vec(pi_a), .po_vec(po_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a));

   c880_bist_harness #(.NUM_PATTERNS(4), .SEED(60'h0), .GOLDEN_SIG(26'hF)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .pi_vec(pi_b), .po_vec(po_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b));

   c880_bist_harness #(.NUM_PATTERNS(4), .SEED(60'h400000000000000), .GOLDEN_SIG(26'h0)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .pi_vec(pi_c), .po_vec(po_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pat_cnt(cnt_c));

   c880_bist_harness #(.NUM_PATTERNS(D_N), .SEED(60'h1), .GOLDEN_SIG(26'h0)) u_d (
      .clk(clk), .rst(rst), .start(start_d), .abort(abort_d), .pi_vec(pi_d), .po_vec(po_d),
      .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d), .pat_cnt(cnt_d));

   c880_bist_harness #(.NUM_PATTERNS(E_N), .SEED(60'h1), .GOLDEN_SIG(E_GOLD)) u_e (
      .clk(clk), .rst(rst), .start(start_e), .abort(abort_e), .pi_vec(pi_e), .po_vec(po_e),
      .busy(busy_e), .done(done_e), .pass(pass_e), .signature(sig_e), .pat_cnt(cnt_e));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic done_of(input int unsigned which);
      case (which)
         3: return done_d;
         4: return done_e;
         default: return done_a;
      endcase
   endfunction

   task automatic wait_done(input int unsigned which, input int unsigned budget);
      int unsigned c;
      c = 0;
      while (done_of(which) == 1'b0 && c < budget) begin
         tick();
         c++;
      end
      check("done_timeout", 64'(done_of(which)), 64'd1);
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      rst = 1'b1;
      {start_a, start_b, start_c, start_d, start_e} = '0;
      {abort_a, abort_b, abort_c, abort_d, abort_e} = '0;
      po_a = '0; po_b = '0; po_c = '0; po_man = '0; man_d = 1'b0; tamper = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_pi",   64'(pi_a),   64'h0);
      check("rst_sig",  64'(sig_a),  64'h0);
      check("rst_cnt",  64'(cnt_a),  64'h0);
      check("rst_busy", 64'(busy_a), 64'h0);
      check("rst_done", 64'(done_a), 64'h0);
      check("rst_pass", 64'(pass_a), 64'h0);

      // Minimal run, po tied low
      start_a = 1'b1; tick(); start_a = 1'b0;
      check("min_busy", 64'(busy_a), 64'h1);
      for (int k = 0; k < 4; k++) begin
         check("min_pi", 64'(pi_a), 64'd1 << k);
         tick();
      end
      check("min_chk_busy", 64'(busy_a), 64'h1);
      check("min_chk_done", 64'(done_a), 64'h0);
      check("min_chk_pi",   64'(pi_a),   64'h8);
      tick();
      check("min_done", 64'(done_a), 64'h1);
      check("min_busy_low", 64'(busy_a), 64'h0);
      check("min_pass", 64'(pass_a), 64'h1);
      check("min_sig",  64'(sig_a),  64'h0);
      check("min_cnt",  64'(cnt_a),  64'h4);
      check("min_pi_clr", 64'(pi_a), 64'h0);

      // Compaction with po=1: A restarts from DONE, B uses SEED=0 and golden F
      po_a = 26'h1; po_b = 26'h1;
      start_a = 1'b1; start_b = 1'b1; tick(); start_a = 1'b0; start_b = 1'b0;
      check("restart_done", 64'(done_a), 64'h0);
      check("restart_sig",  64'(sig_a),  64'h0);
      check("restart_cnt",  64'(cnt_a),  64'h0);
      check("seed0_pi",     64'(pi_b),   64'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("cmp_sig", 64'(sig_a), (64'd1 << (k + 1)) - 64'd1);
      end
      tick();
      check("cmp_done_a", 64'(done_a), 64'h1);
      check("cmp_pass_a", 64'(pass_a), 64'h0);
      check("cmp_sig_a",  64'(sig_a),  64'hF);
      check("cmp_done_b", 64'(done_b), 64'h1);
      check("cmp_pass_b", 64'(pass_b), 64'h1);
      check("cmp_sig_b",  64'(sig_b),  64'hF);
      po_a = '0; po_b = '0;

      // LFSR feedback from bit 58, then abort during RUN
      start_c = 1'b1; tick(); start_c = 1'b0;
      check("fb_seed", 64'(pi_c), 64'h400000000000000);
      tick();
      check("fb_next", 64'(pi_c), 64'h800000000000001);
      abort_c = 1'b1; tick(); abort_c = 1'b0;
      check("abt_c_busy", 64'(busy_c), 64'h0);
      check("abt_c_done", 64'(done_c), 64'h0);
      check("abt_c_pi",   64'(pi_c),   64'h0);
      check("abt_c_cnt",  64'(cnt_c),  64'h1);

      // MISR feedback: walk a single 1 up to bit 25, then shift it out
      man_d = 1'b1; po_man = 26'h1;
      start_d = 1'b1; tick(); start_d = 1'b0;
      tick(); po_man = 26'h0;
      check("misr_one", 64'(sig_d), 64'h1);
      repeat (25) tick();
      check("misr_top", 64'(sig_d), 64'h2000000);
      tick();
      check("misr_fb", 64'(sig_d), 64'h0000047);
      abort_d = 1'b1; tick(); abort_d = 1'b0;
      check("abt_keep_sig", 64'(sig_d),  64'h0000047);
      check("abt_keep_cnt", 64'(cnt_d),  64'd27);
      check("abt_d_busy",   64'(busy_d), 64'h0);
      man_d = 1'b0;

      // Abort on cycle 50, then a complete run with a stray start ignored
      start_d = 1'b1; tick(); start_d = 1'b0;
      repeat (49) tick();
      abort_d = 1'b1; tick(); abort_d = 1'b0;
      check("abt50_busy", 64'(busy_d), 64'h0);
      check("abt50_done", 64'(done_d), 64'h0);
      check("abt50_pi",   64'(pi_d),   64'h0);
      check("abt50_pass", 64'(pass_d), 64'h0);
      start_d = 1'b1; tick(); start_d = 1'b0;
      repeat (10) tick();
      start_d = 1'b1; tick(); start_d = 1'b0;
      wait_done(3, 200);
      check("full_sig",  64'(sig_d),  64'(model_sig(D_N, 60'h1, 1'b0)));
      check("full_cnt",  64'(cnt_d),  64'(D_N));
      check("full_busy", 64'(busy_d), 64'h0);

      // Reset mid-run clears everything; the rerun reproduces the signature
      start_d = 1'b1; tick(); start_d = 1'b0;
      repeat (30) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("mrst_pi",   64'(pi_d),   64'h0);
      check("mrst_sig",  64'(sig_d),  64'h0);
      check("mrst_cnt",  64'(cnt_d),  64'h0);
      check("mrst_busy", 64'(busy_d), 64'h0);
      check("mrst_done", 64'(done_d), 64'h0);
      start_d = 1'b1; tick(); start_d = 1'b0;
      wait_done(3, 200);
      check("rerun_sig", 64'(sig_d), 64'(model_sig(D_N, 60'h1, 1'b0)));

      // Golden versus tampered stand-in
      tamper = 1'b0;
      start_e = 1'b1; tick(); start_e = 1'b0;
      wait_done(4, 200);
      check("gold_pass", 64'(pass_e), 64'h1);
      check("gold_sig",  64'(sig_e),  64'(E_GOLD));
      tamper = 1'b1;
      start_e = 1'b1; tick(); start_e = 1'b0;
      check("tamp_busy", 64'(busy_e), 64'h1);
      check("tamp_done", 64'(done_e), 64'h0);
      wait_done(4, 200);
      check("tamp_pass", 64'(pass_e), 64'h0);
      check("tamp_sig",  64'(sig_e),  64'(model_sig(E_N, 60'h1, 1'b1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/c880_bist_harness.md
# c880_bist_harness

Self-test harness for the ISCAS c880 pattern set. It generates 60-bit pseudo-random stimulus for the c880 primary inputs and compacts the 26-bit primary-output responses into a MISR signature. At the end of a run it compares the signature with a golden value. A deviation flags a modified netlist, for example an inserted trojan at an internal node. The harness sits between the detection flow's control logic and the combinational c880 (or c880-variant) instance: it drives `pi_vec` and reads `po_vec`.

## Interface

Parameters:
- `NUM_PATTERNS`, 1024: patterns per run; legal range 1..65535.
- `SEED`, 60'h1: LFSR start state. A value of 0 is replaced by 60'h1.
- `GOLDEN_SIG`, 26'h0: expected final MISR signature.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begins a run when sampled high in IDLE or DONE; ignored otherwise.
- `abort` in 1: cancels any run and returns to IDLE.
- `pi_vec` out 60: stimulus to the DUT inputs N1..N268, bit 0 = N1, in netlist order.
- `po_vec` in 26: DUT outputs N388..N880, bit 0 = N388, in netlist order.
- `busy` out 1: high in RUN and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: comparison result; valid while `done` is high.
- `signature` out 26: live MISR contents.
- `pat_cnt` out 16: number of patterns absorbed in the current or last run.

## Operation

- Reset (`rst`=1 at an edge) sets state IDLE and clears `pi_vec`, `signature`, `pat_cnt`, `busy`, `done` and `pass` to 0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE on `start`:
  - `pi_vec` <= SEED (or 1 if SEED is 0), `signature` <= 0, `pat_cnt` <= 0, `pass` <= 0.
  - Next state RUN.
- RUN, every cycle:
  - `signature` <= MISR_next(`signature`, `po_vec`).
  - `pi_vec` <= LFSR_next(`pi_vec`).
  - `pat_cnt` <= `pat_cnt`+1.
  - When `pat_cnt` == NUM_PATTERNS-1 at the edge, next state is CHECK and `pi_vec` is not advanced.
- CHECK, one cycle:
  - `pass` <= (`signature` == GOLDEN_SIG).
  - `pi_vec` <= 0.
  - Next state DONE.
- DONE: hold `signature`, `pat_cnt` and `pass`. `start` restarts exactly as from IDLE.
- `abort` from any state: next state IDLE, `pi_vec` <= 0, `pass` <= 0. `signature` and `pat_cnt` keep their last values.
- Priority: `rst` over `abort` over `start`.
- LFSR: Fibonacci, polynomial x^60+x^59+1.
  - fb = `pi_vec`[59] ^ `pi_vec`[58].
  - LFSR_next = {`pi_vec`[58:0], fb}.
  - Period is 2^60-1, so patterns never repeat within a run.
- MISR: polynomial x^26+x^6+x^2+x+1, POLY = 26'h0000047.
  - MISR_next = {s[24:0],1'b0} ^ (s[25] ? POLY : 0) ^ `po_vec`.
- `pat_cnt` is 16 bits and never wraps, because NUM_PATTERNS is at most 65535.

## Timing

- The DUT is combinational in the same clock domain. The response to the pattern held in `pi_vec` during cycle k is absorbed at the edge ending cycle k.
- Pattern 0 appears in `pi_vec` the cycle after `start` is sampled.
- A run lasts 1 (load) + NUM_PATTERNS (RUN) + 1 (CHECK) cycles.
- `done` and `pass` are valid in cycle NUM_PATTERNS+2 after the `start` edge and stay stable until the next `start`, `abort` or `rst`.
- `busy` and `done` are never high together. `busy` drops in the same cycle that `done` rises.
- A `start` arriving during RUN or CHECK is ignored and is not queued.
- Reset mid-run takes effect at the next edge with the full reset values above. No partial signature survives.
- All outputs are registered. No output has a combinational path from `po_vec`.

## Test plan

- **Minimal run.** NUM_PATTERNS=4, SEED=1, `po_vec` tied to 0, GOLDEN_SIG=0, pulse `start`.
  - `pi_vec` sequence: 1, 2, 4, 8.
  - `done`=1 and `pass`=1 on cycle 6 after `start`.
  - `signature`=0 and `pat_cnt`=4.
- **Compaction.** Same setup with `po_vec` tied to 26'h1.
  - `signature` sequence: 1, 3, 7, F.
  - Final value 26'h000000F, so `pass`=0 with GOLDEN_SIG=0 and `pass`=1 with GOLDEN_SIG=26'hF.
- **Feedback paths.**
  - SEED=60'h400000000000000 (bit 58 set): the next `pi_vec` is 60'h800000000000001.
  - MISR preloaded with 26'h2000000 and `po_vec`=0: the next value is 26'h0000047.
- **Abort mid-run.** NUM_PATTERNS=100, assert `abort` on cycle 50.
  - The next cycle shows IDLE: `busy`=0, `done`=0, `pi_vec`=0.
  - A following `start` completes normally with the same signature as an uninterrupted run.
- **Reset and restart.**
  - Assert `rst` mid-run: all outputs are 0 after the edge.
  - `start` in DONE restarts, and the identical run reproduces the identical signature.
  - SEED=0 behaves exactly like SEED=1.
- **Golden versus tampered DUT.** NUM_PATTERNS=1024, golden c880 versus a variant whose node 773 feeds a constant-1 net.
  - The golden DUT gives `pass`=1 when GOLDEN_SIG is taken from the golden run.
  - The tampered DUT gives `pass`=0.
